// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction encodings and helpers for the snake direction scheduler
package snake_pkg;

  localparam int DIR_W = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

  // Opposite pairs share bit1 and differ in bit0.
  function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// rtl/dir_fifo.sv - QDEPTH x 2-bit circular turn FIFO with flush; push and pop together are legal when full
module dir_fifo
  import snake_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int QW     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [DIR_W-1:0] din,
  output logic [DIR_W-1:0] head,
  output logic [DIR_W-1:0] tail,
  output logic [QW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] LAST = 2'(QDEPTH - 1);

  logic [DIR_W-1:0] mem [4];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [1:0]       tail_ptr;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign tail_ptr = (wr_ptr == 2'd0) ? LAST : wr_ptr - 2'd1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];
  assign empty    = (count == '0);
  assign full     = (count == QW'(QDEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + QW'(1);
      else if (pop && !push) count <= count - QW'(1);
    end
  end

  // When full, the slot written is the one being popped this edge; the pop reads the old value.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - snake direction scheduler: edge detect, arbitration, legality, tick release
// Optional pause toggling is built when PAUSE_TOGGLE_EN is defined.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int QW     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       btn_lvl,
  input  logic             btn_pause,
  input  logic             tick,
  output logic [DIR_W-1:0] dir,
  output logic             dir_chg,
  output logic [QW-1:0]    q_count,
  output logic             drop,
  output logic             paused
);

  logic [3:0]       prev_lvl;
  logic [3:0]       rise;
  logic             cand_valid;
  logic [DIR_W-1:0] cand;
  logic [DIR_W-1:0] ref_dir;
  logic             legal;
  logic             active;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [DIR_W-1:0] head;
  logic [DIR_W-1:0] tail;

  assign rise = btn_lvl & ~prev_lvl;

  always_comb begin
    cand_valid = |rise;
    cand       = DIR_RIGHT;
    if (rise[3])      cand = DIR_UP;
    else if (rise[2]) cand = DIR_DOWN;
    else if (rise[1]) cand = DIR_LEFT;
  end

  // Legality is judged against where the snake will be heading once the queue drains.
  assign ref_dir = empty ? dir : tail;
  assign legal   = cand_valid && (cand != ref_dir) && (cand != dir_opposite(ref_dir));
  assign active  = en && !clr && !paused;
  assign pop     = active && tick && !empty;
  assign push    = active && legal && (!full || pop);

  dir_fifo #(
    .QDEPTH(QDEPTH),
    .QW    (QW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(clr || !en),
    .push (push),
    .pop  (pop),
    .din  (cand),
    .head (head),
    .tail (tail),
    .count(q_count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_lvl <= 4'b1111;
      dir      <= DIR_RIGHT;
      dir_chg  <= 1'b0;
      drop     <= 1'b0;
    end else begin
      prev_lvl <= btn_lvl;
      dir_chg  <= pop;
      drop     <= active && legal && full && !pop;
      if (clr)      dir <= DIR_RIGHT;
      else if (pop) dir <= head;
    end
  end

`ifdef PAUSE_TOGGLE_EN
  logic prev_pause;
  logic paused_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pause <= 1'b1;
      paused_q   <= 1'b0;
    end else begin
      prev_pause <= btn_pause;
      if (clr)                                   paused_q <= 1'b0;
      else if (en && btn_pause && !prev_pause)   paused_q <= ~paused_q;
    end
  end

  assign paused = paused_q;
`else
  logic unused_pause;
  assign unused_pause = btn_pause;
  assign paused       = 1'b0;
`endif

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - scoreboard bench for snake_dir_ctrl against a queue-based reference model
module tb_snake_dir_ctrl;

  localparam int QDEPTH = 2;
  localparam int QW     = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          en = 1'b1;
  logic [3:0]    btn_lvl = 4'b1111;
  logic          btn_pause = 1'b1;
  logic          tick = 1'b0;
  logic [1:0]    dir;
  logic          dir_chg;
  logic [QW-1:0] q_count;
  logic          drop;
  logic          paused;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] dir;
    logic       chg;
    logic [1:0] cnt;
    logic       drop;
    logic       paused;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_prev;
  logic [1:0] m_q[$];
  logic [1:0] m_dir;
  logic       m_paused;
`ifdef PAUSE_TOGGLE_EN
  logic       m_pprev;
`endif

  snake_dir_ctrl #(.QDEPTH(QDEPTH), .QW(QW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .btn_lvl  (btn_lvl),
    .btn_pause(btn_pause),
    .tick     (tick),
    .dir      (dir),
    .dir_chg  (dir_chg),
    .q_count  (q_count),
    .drop     (drop),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  // Reference: the turn queue is a plain list; a tick takes the oldest turn, a legal press appends
  // if there is room once that tick's pop has happened.
  task automatic model(input logic r, c, e, input logic [3:0] l, input logic p, t);
    logic [3:0] rise;
    logic [1:0] cand;
    logic [1:0] refd;
    bit found, legal, chg, drp;
    chg = 0;
    drp = 0;
    cand = 2'b11;
    if (r) begin
      m_prev = 4'hf;
      m_q.delete();
      m_dir = 2'b11;
      m_paused = 1'b0;
`ifdef PAUSE_TOGGLE_EN
      m_pprev = 1'b1;
`endif
    end else begin
      rise = l & ~m_prev;
      m_prev = l;
      if (c) begin
        m_q.delete();
        m_dir = 2'b11;
        m_paused = 1'b0;
      end else if (!e) begin
        m_q.delete();
      end else begin
        if (!m_paused) begin
          found = 0;
          for (int i = 3; i >= 0; i--)
            if (!found && rise[i]) begin
              found = 1;
              cand = 2'(3 - i);
            end
          refd = (m_q.size() > 0) ? m_q[$] : m_dir;
          legal = found && (cand != refd) && ((cand ^ refd) != 2'b01);
          if (t && m_q.size() > 0) begin
            m_dir = m_q.pop_front();
            chg = 1;
          end
          if (legal) begin
            if (m_q.size() < QDEPTH) m_q.push_back(cand);
            else drp = 1;
          end
        end
`ifdef PAUSE_TOGGLE_EN
        if (p && !m_pprev) m_paused = !m_paused;
`endif
      end
`ifdef PAUSE_TOGGLE_EN
      m_pprev = p;
`endif
    end
    exp_q.push_back('{dir: m_dir, chg: chg, cnt: 2'(m_q.size()), drop: drp, paused: m_paused});
  endtask

  task automatic cyc(input logic r, c, e, input logic [3:0] l, input logic p, t);
    @(negedge clk);
    rst = r; clr = c; en = e; btn_lvl = l; btn_pause = p; tick = t;
    model(r, c, e, l, p, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 4'b0000, 0, 0);
  endtask

  task automatic press(input logic [3:0] l, input logic t);
    cyc(0, 0, 1, l, 0, t);
    cyc(0, 0, 1, 4'b0000, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dir", 8'(dir), 8'(e.dir));
        chk("dir_chg", 8'(dir_chg), 8'(e.chg));
        chk("q_count", 8'(q_count), 8'(e.cnt));
        chk("drop", 8'(drop), 8'(e.drop));
        chk("paused", 8'(paused), 8'(e.paused));
      end
    end
  end

  initial begin : driver
    logic [3:0] lvl;
    logic       pz;
    logic       ena;
    // Reset with UP held, then keep holding: no edge may be seen.
    cyc(1, 0, 1, 4'b1000, 0, 0);
    cyc(1, 0, 1, 4'b1000, 0, 0);
    cyc(0, 0, 1, 4'b1000, 0, 0);
    cyc(0, 0, 1, 4'b1000, 0, 0);
    idle(1);
    // UP then LEFT a few cycles later, released by two ticks.
    press(4'b1000, 0);
    idle(2);
    press(4'b0010, 0);
    press(4'b0000, 1);
    press(4'b0000, 1);
    idle(1);
    // Opposite and same-direction presses are rejected silently.
    cyc(0, 1, 1, 4'b0000, 0, 0);
    press(4'b0010, 0);
    press(4'b0001, 0);
    // Fill the queue, overflow, then overflow with a same-cycle tick.
    press(4'b1000, 0);
    press(4'b0010, 0);
    press(4'b1000, 0);
    press(4'b1000, 1);
    idle(1);
    // Simultaneous UP and LEFT edges: UP wins.
    cyc(0, 1, 1, 4'b0000, 0, 0);
    press(4'b1010, 0);
    press(4'b0000, 1);
    // clr with a full queue and a tick in the same cycle.
    press(4'b0010, 0);
    press(4'b1000, 0);
    cyc(0, 1, 1, 4'b0000, 0, 1);
    idle(1);
    // en low flushes and ignores presses and ticks.
    press(4'b1000, 0);
    cyc(0, 0, 0, 4'b0010, 0, 1);
    cyc(0, 0, 0, 4'b0000, 0, 1);
    idle(1);
    // Pause edge, tick, second pause edge, tick.
    press(4'b0010, 0);
    cyc(0, 0, 1, 4'b0000, 1, 0);
    cyc(0, 0, 1, 4'b0000, 0, 1);
    cyc(0, 0, 1, 4'b0000, 1, 0);
    cyc(0, 0, 1, 4'b0000, 0, 1);
    idle(1);
    // Randomized traffic, including occasional clr, en drops and mid-run resets.
    lvl = 4'b0000;
    pz = 1'b0;
    ena = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) lvl[b] = ~lvl[b];
      if ($urandom_range(9) == 0) pz = ~pz;
      if ($urandom_range(40) == 0) ena = ~ena;
      cyc(($urandom_range(250) == 0), ($urandom_range(80) == 0), ena, lvl, pz,
          ($urandom_range(3) == 0));
    end
    idle(2);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
